pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined add/subtract unit with valid/ready flow control on both sides. It is the successor to the single-stage registered adder. It adds configurable operand width and pipeline depth, a per-transaction add/subtract select, full backpressure, and a wrapping completion counter. It sits between a stimulus/producer interface and a consumer that may stall.

## Interface
- `WIDTH`, default 8: operand width in bits, must be ≥ 2.
- `DEPTH`, default 3: pipeline stages, must be ≥ 1. This is the input-to-output latency when there is no stall.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset (0 = reset asserted).
- `in_valid`  in  1: producer presents `a`, `b`, `sub`.
- `in_ready`  out  1: unit accepts the transaction this cycle.
- `a`  in  WIDTH: operand A, unsigned.
- `b`  in  WIDTH: operand B, unsigned.
- `sub`  in  1: 0 selects a+b; 1 selects a−b.
- `out_valid`  out  1: `c` holds a result.
- `out_ready`  in  1: consumer takes the result this cycle.
- `c`  out  WIDTH+1: result; encoding is defined under Operation and Configuration.
- `done_cnt`  out  16: count of results handed off.

## Operation
- **Input handshake:** a transaction is accepted on a rising edge where `in_valid && in_ready`.
- **Output handshake:** a transaction is retired on a rising edge where `out_valid && out_ready`.
- **Stage 0:** computes the result from `a`, `b`, `sub` on acceptance and registers it with a valid bit. Stages 1..DEPTH−1 only move data.
- **Advance rule:** a stage advances when its successor is empty, or when its successor is itself advancing this cycle. The last stage "advances" when `out_ready` is high. Bubbles collapse, so there is no throughput loss while `out_ready` stays high.
- **in_ready:** `in_ready = reset && (stage0 empty || stage0 advancing)`. It is combinational from `out_ready` through the stage valids. There is no combinational path from `in_valid` to `in_ready`.
- **Stall:** when `out_ready` is low and the pipeline is full, every stage holds its data and `in_ready` is 0. Results are never dropped or duplicated, and order is preserved.
- **Arithmetic, add:** `c = {carry, (a+b) mod 2^WIDTH}`.
- **Arithmetic, subtract:** `c = {borrow, (a−b) mod 2^WIDTH}`, where `borrow = (a < b)`.
- **done_cnt:** increments by 1 on every output handshake and wraps from 0xFFFF to 0x0000.
- **Simultaneous accept and retire in one cycle:** both take effect. Occupancy stays unchanged if the pipeline was full.

## Timing
- **Reset values:** while `reset`=0, all stage valids clear asynchronously. Outputs are `out_valid`=0, `c`=0, `done_cnt`=0, `in_ready`=0.
- **After reset:** `in_ready` rises combinationally on deassertion, once the pipe is empty.
- **Latency:** a transaction accepted at edge N shows `out_valid`=1 after edge N+DEPTH−1 and can be retired at edge N+DEPTH, provided no stall occurs.
- **Holding outputs:** `c` and `out_valid` are registered. They hold stable while `out_valid && !out_ready`.
- **Capacity:** at most DEPTH results in flight.
- **Reset mid-operation:** all in-flight results are discarded and `done_cnt` clears. Nothing is emitted after reset is released until new input is accepted.
- **DEPTH=1:** a single register stage. `in_ready = reset && (!out_valid || out_ready)`.

## Configuration
- **`PIPE_ADDER_SAT_EN` defined:**
  - `c[WIDTH-1:0]` saturates: an add that overflows gives all ones; a subtract that underflows gives 0.
  - `c[WIDTH]` is the saturation flag (1 when clamping occurred).
  - Non-saturating results are the same as in the default mode, with `c[WIDTH]`=0.
- **`PIPE_ADDER_SAT_EN` undefined:** wrap-around arithmetic as described under Operation.
- **Unaffected either way:** the handshake, latency and counter behaviour.

## Test plan
All scenarios use WIDTH=8, DEPTH=3.
1. **Reset:** hold `reset`=0 with `in_valid`=1 → `out_valid`=0, `c`=0, `done_cnt`=0, `in_ready`=0. Release → `in_ready`=1 within the same cycle.
2. **Single add:** `a`=200, `b`=100, `sub`=0, `out_ready`=1 → 3 edges later `c`=0x12C (carry=1, sum 44), `done_cnt`=1. With SAT_EN: `c`=0x1FF.
3. **Subtract with borrow:** `a`=5, `b`=9, `sub`=1 → `c`=0x1FC. With SAT_EN: `c`=0x100.
4. **Back-to-back stream:** 10 transactions with `a`=i, `b`=i, `out_ready`=1 every cycle → 10 consecutive `out_valid` cycles with `c`=2i, in order, and `done_cnt`=10.
5. **Backpressure:** `out_ready`=0 while pushing → exactly 3 accepted, then `in_ready`=0 and `c` held stable. Raise `out_ready` → all results drain in order with none lost or duplicated. With a full pipe, accept and retire occur in the same cycle.
6. **Abort and wrap:** assert reset with 2 results in flight → no stale output appears after release. Preload 0xFFFF handshakes → `done_cnt` wraps to 0.

Source files
------------

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/subtract with valid/ready flow control and a wrapping completion counter.
// Define PIPE_ADDER_SAT_EN for saturating arithmetic, with c[WIDTH] as the clamp flag.
module pipe_adder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   c,
    output logic [15:0]      done_cnt
);
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] acc;
    logic [WIDTH:0]   dat [DEPTH];
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   res;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
`ifdef PIPE_ADDER_SAT_EN
        res  = sub ? (diff[WIDTH] ? {1'b1, {WIDTH{1'b0}}} : diff)
                   : (sum[WIDTH]  ? {1'b1, {WIDTH{1'b1}}} : sum);
`else
        res  = sub ? diff : sum;
`endif
    end

    // A stage can take new data if any stage at or beyond it has a hole, or the consumer is draining.
    for (genvar i = 0; i < DEPTH; i++) begin : g_acc
        assign acc[i] = out_ready || !(&vld[DEPTH-1:i]);
    end

    assign in_ready  = reset && acc[0];
    assign out_valid = vld[DEPTH-1];
    assign c         = dat[DEPTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld      <= '0;
            done_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
        end else begin
            if (acc[0]) begin
                vld[0] <= in_valid;
                dat[0] <= res;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (acc[i]) begin
                    vld[i] <= vld[i-1];
                    dat[i] <= dat[i-1];
                end
            end
            if (vld[DEPTH-1] && out_ready) done_cnt <= done_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: table vectors, directed corner sequences and a random stream against a queue-based model.
module tb_pipe_adder;
    localparam int W = 8;
    localparam int D = 3;

    logic         clk = 0;
    logic         reset = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [W-1:0] a = 0;
    logic [W-1:0] b = 0;
    logic         sub = 0;
    logic         out_valid;
    logic         out_ready = 0;
    logic [W:0]   c;
    logic [15:0]  done_cnt;

    int errors = 0;
    int checks = 0;

    pipe_adder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W:0] model(input int x, input int y, input bit s);
        int r;
        r = s ? x - y : x + y;
`ifdef PIPE_ADDER_SAT_EN
        if (r > 255) return 9'h1FF;
        if (r < 0) return 9'h100;
        return 9'(r);
`else
        return 9'((r + 512) % 512);
`endif
    endfunction

    typedef struct { logic [W:0] c; int t; } item_t;
    item_t       q[$];
    int          cyc = 0;
    logic [15:0] mcnt = 0;
    bit          prev_stall = 0;
    logic [W:0]  prev_c = 0;

    // Model: FIFO of expected results stamped with their acceptance cycle.
    always @(negedge clk) begin
        bit exp_ir, exp_ov;
        if (!reset) begin
            check(out_valid === 1'b0, "rst_out_valid", 32'(out_valid), 0);
            check(c === '0, "rst_c", 32'(c), 0);
            check(done_cnt === 16'd0, "rst_done_cnt", 32'(done_cnt), 0);
            check(in_ready === 1'b0, "rst_in_ready", 32'(in_ready), 0);
            q.delete();
            mcnt = 0;
            prev_stall = 0;
        end else begin
            exp_ir = q.size() < D || out_ready;
            exp_ov = q.size() > 0 && (cyc - q[0].t) >= D;
            check(in_ready === exp_ir, "in_ready", 32'(in_ready), 32'(exp_ir));
            check(out_valid === exp_ov, "out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) check(c === q[0].c, "c_order", 32'(c), 32'(q[0].c));
            check(done_cnt === mcnt, "done_cnt", 32'(done_cnt), 32'(mcnt));
            if (prev_stall) check(c === prev_c, "c_hold", 32'(c), 32'(prev_c));
            prev_stall = out_valid && !out_ready;
            prev_c = c;
            if (exp_ov && out_ready) begin
                void'(q.pop_front());
                mcnt++;
            end
            if (in_valid && exp_ir) q.push_back('{model(a, b, sub), cyc});
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [W-1:0] a, b; bit s; logic [W:0] exp; } vec_t;

    initial begin
        vec_t vecs[8];
        int   acc_n;
        bit   seen;
`ifdef PIPE_ADDER_SAT_EN
        vecs = '{'{200, 100, 0, 9'h1FF}, '{5, 9, 1, 9'h100}, '{0, 0, 0, 9'h000}, '{255, 255, 0, 9'h1FF},
                 '{255, 0, 1, 9'h0FF}, '{0, 1, 1, 9'h100}, '{100, 100, 1, 9'h000}, '{128, 127, 0, 9'h0FF}};
`else
        vecs = '{'{200, 100, 0, 9'h12C}, '{5, 9, 1, 9'h1FC}, '{0, 0, 0, 9'h000}, '{255, 255, 0, 9'h1FE},
                 '{255, 0, 1, 9'h0FF}, '{0, 1, 1, 9'h1FF}, '{100, 100, 1, 9'h000}, '{128, 127, 0, 9'h0FF}};
`endif
        // Reset held with a pending producer, then release.
        in_valid = 1; a = 8'd33; b = 8'd44; out_ready = 1;
        repeat (3) step();
        reset = 1; in_valid = 0;
        #1 check(in_ready === 1'b1, "in_ready_on_release", 32'(in_ready), 1);
        step();

        foreach (vecs[k]) begin
            in_valid = 1; a = vecs[k].a; b = vecs[k].b; sub = vecs[k].s;
            step();
            in_valid = 0;
            @(posedge clk); @(posedge clk); @(negedge clk);
            check(out_valid === 1'b1, "vec_valid", 32'(out_valid), 1);
            check(c === vecs[k].exp, "vec_c", 32'(c), 32'(vecs[k].exp));
            step();
            #1 check(done_cnt === 16'(k + 1), "vec_cnt", 32'(done_cnt), 32'(k + 1));
        end

        // Back-to-back stream of 10.
        reset = 0; step(); reset = 1; step();
        sub = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    in_valid = 1; a = 8'(i); b = 8'(i);
                    step();
                end
                in_valid = 0;
            end
            begin
                seen = 0;
                for (int n = 0; n < 20 && !seen; n++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                check(seen, "stream_timeout", 32'(seen), 1);
                for (int i = 0; i < 10; i++) begin
                    check(out_valid === 1'b1, "stream_valid", 32'(out_valid), 1);
                    check(c === 9'(2 * i), "stream_c", 32'(c), 32'(2 * i));
                    @(negedge clk);
                end
            end
        join
        repeat (3) step();
        check(done_cnt === 16'd10, "stream_cnt", 32'(done_cnt), 10);

        // Backpressure: fill, stall, accept-with-retire, drain.
        out_ready = 0; acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
            @(negedge clk);
            if (in_ready) acc_n++;
            step();
        end
        check(acc_n == 3, "bp_accepted", 32'(acc_n), 3);
        check(in_ready === 1'b0, "bp_in_ready", 32'(in_ready), 0);
        out_ready = 1;
        #1 check(in_ready === 1'b1 && out_valid === 1'b1, "bp_accept_retire", 32'({in_ready, out_valid}), 3);
        step();
        in_valid = 0;
        repeat (8) step();
        check(out_valid === 1'b0, "bp_drained", 32'(out_valid), 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
            step();
        end
        in_valid = 0; out_ready = 1;
        repeat (8) step();

        // Abort with two in flight.
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; a = 8'(50 + i); b = 8'(7); sub = 0;
            step();
        end
        in_valid = 0;
        reset = 0;
        #1 check(out_valid === 1'b0, "abort_valid", 32'(out_valid), 0);
        step();
        reset = 1; out_ready = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check(!seen, "abort_stale", 32'(seen), 0);

        // Counter wrap.
        step();
        in_valid = 1;
        for (int i = 0; i < 65535; i++) begin
            a = 8'(i); b = 8'(i >> 8); sub = 1'(i);
            step();
        end
        in_valid = 0;
        repeat (5) step();
        check(done_cnt === 16'hFFFF, "cnt_full", 32'(done_cnt), 32'hFFFF);
        in_valid = 1; step(); in_valid = 0;
        repeat (5) step();
        check(done_cnt === 16'h0000, "cnt_wrap", 32'(done_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
